// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle of the data cache controller.
// The controller connects through the slave modport; the CPU/memory side uses master.
interface dcache_controller_if #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int BLOCK_SIZE    = 128,
    parameter int WORD_WIDTH    = 32
) ();
    logic [ADDRESS_WIDTH-1:0] i_CpuAddress;
    logic [WORD_WIDTH-1:0]    i_CpuWriteData;
    logic                     i_CpuRead;
    logic                     i_CpuWrite;
    logic [WORD_WIDTH-1:0]    o_CpuReadData;
    logic                     o_CpuStall;
    logic                     o_MemReadEnable;
    logic                     o_MemWriteEnable;
    logic [ADDRESS_WIDTH-1:0] o_MemAddressCpu;
    logic [ADDRESS_WIDTH-1:0] o_MemAddressCache;
    logic [BLOCK_SIZE-1:0]    o_MemDataToMem;
    logic [BLOCK_SIZE-1:0]    i_MemDataToCache;
    logic                     i_MemReady;
    logic [15:0]              o_HitCount;
    logic [15:0]              o_MissCount;

    modport slave (
        input  i_CpuAddress, i_CpuWriteData, i_CpuRead, i_CpuWrite,
        input  i_MemDataToCache, i_MemReady,
        output o_CpuReadData, o_CpuStall,
        output o_MemReadEnable, o_MemWriteEnable,
        output o_MemAddressCpu, o_MemAddressCache, o_MemDataToMem,
        output o_HitCount, o_MissCount
    );

    modport master (
        output i_CpuAddress, i_CpuWriteData, i_CpuRead, i_CpuWrite,
        output i_MemDataToCache, i_MemReady,
        input  o_CpuReadData, o_CpuStall,
        input  o_MemReadEnable, o_MemWriteEnable,
        input  o_MemAddressCpu, o_MemAddressCache, o_MemDataToMem,
        input  o_HitCount, o_MissCount
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with
// single-cycle hits and a level-enable/ready block memory interface.
module dcache_controller #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int BLOCK_SIZE    = 128,
    parameter int WORD_WIDTH    = 32,
    parameter int NUM_LINES     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    dcache_controller_if.slave   bus
);
    // state     | meaning
    // S_IDLE    | serving hits; a miss is detected and latched here
    // S_WRBACK  | dirty victim block being written to memory
    // S_ALLOC   | requested block being refilled from memory
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRBACK = 2'd1;
    localparam logic [1:0] S_ALLOC  = 2'd2;

    localparam int WORDS    = BLOCK_SIZE / WORD_WIDTH;
    localparam int OFFSET_W = $clog2(WORDS);
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int TAG_W    = ADDRESS_WIDTH - OFFSET_W - INDEX_W;

    logic [1:0]                          state;
    logic [NUM_LINES-1:0]                valid;
    logic [NUM_LINES-1:0]                dirty;
    logic [TAG_W-1:0]                    tag_mem  [NUM_LINES];
    logic [WORDS-1:0][WORD_WIDTH-1:0]    data_mem [NUM_LINES];
    logic [ADDRESS_WIDTH-1:0]            req_addr;
    logic [ADDRESS_WIDTH-1:0]            wb_addr;
    logic [BLOCK_SIZE-1:0]               wb_data;
    logic [15:0]                         hit_cnt;
    logic [15:0]                         miss_cnt;

    logic [OFFSET_W-1:0] cpu_off;
    logic [INDEX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                request;
    logic                hit;
    logic                in_idle;
    logic                fill_en;
    logic                store_en;

    assign cpu_off  = bus.i_CpuAddress[OFFSET_W-1:0];
    assign cpu_idx  = bus.i_CpuAddress[OFFSET_W +: INDEX_W];
    assign cpu_tag  = bus.i_CpuAddress[ADDRESS_WIDTH-1 -: TAG_W];
    assign req_idx  = req_addr[OFFSET_W +: INDEX_W];
    assign req_tag  = req_addr[ADDRESS_WIDTH-1 -: TAG_W];

    assign request  = bus.i_CpuRead | bus.i_CpuWrite;
    assign hit      = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign in_idle  = (state == S_IDLE);
    assign fill_en  = (state == S_ALLOC) && bus.i_MemReady;
    assign store_en = in_idle && bus.i_CpuWrite && hit;

    assign bus.o_CpuStall        = !in_idle || (request && !hit);
    assign bus.o_CpuReadData     = (in_idle && hit && bus.i_CpuRead && !bus.i_CpuWrite)
                                   ? data_mem[cpu_idx][cpu_off] : '0;
    assign bus.o_MemWriteEnable  = (state == S_WRBACK);
    assign bus.o_MemReadEnable   = (state == S_ALLOC);
    assign bus.o_MemAddressCpu   = req_addr;
    assign bus.o_MemAddressCache = wb_addr;
    assign bus.o_MemDataToMem    = wb_data;
    assign bus.o_HitCount        = hit_cnt;
    assign bus.o_MissCount       = miss_cnt;

    // Tag and data storage carry no reset; valid bits alone define contents.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (fill_en) begin
                tag_mem[req_idx]  <= req_tag;
                data_mem[req_idx] <= bus.i_MemDataToCache;
            end else if (store_en) begin
                data_mem[cpu_idx][cpu_off] <= bus.i_CpuWriteData;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            valid    <= '0;
            dirty    <= '0;
            req_addr <= '0;
            wb_addr  <= '0;
            wb_data  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (request && hit) begin
                        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                        if (bus.i_CpuWrite) dirty[cpu_idx] <= 1'b1;
                    end else if (request) begin
                        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                        req_addr <= {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
                        if (valid[cpu_idx] && dirty[cpu_idx]) begin
                            wb_addr <= {tag_mem[cpu_idx], cpu_idx, {OFFSET_W{1'b0}}};
                            wb_data <= data_mem[cpu_idx];
                            state   <= S_WRBACK;
                        end else begin
                            state   <= S_ALLOC;
                        end
                    end
                end
                S_WRBACK: begin
                    if (bus.i_MemReady) begin
                        dirty[req_idx] <= 1'b0;
                        state          <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (bus.i_MemReady) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Randomized self-checking bench: cache controller against an architectural
// word-memory reference plus a block memory with random ready latency.
module tb_dcache_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_controller_if bus ();

    dcache_controller dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural reference: what each word address should read back,
    // plus which block each index currently holds and whether it was modified.
    logic [31:0] mem      [1024];
    logic [31:0] ref_arch [1024];
    bit          res_valid [16];
    bit          res_dirty [16];
    int          res_tag   [16];
    int          hit_m, miss_m;

    logic [9:0]   exp_wb_addr, exp_rd_addr;
    logic [127:0] exp_wb_data;
    bit           m_hit;
    int           m_ops;
    logic [9:0]   last_wb_addr, last_rd_addr;
    logic [127:0] last_wb_data;

    int mem_lat_min = 0, mem_lat_max = 0;
    int lat_left  = -1;
    int mem_ops   = 0;
    int mem_waits = 0;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Block memory: samples enables on the falling edge, answers after a random delay.
    always @(negedge clk) begin
        int base;
        if (bus.o_MemReadEnable || bus.o_MemWriteEnable) begin
            check_eq("mem_enable_excl", {bus.o_MemReadEnable, bus.o_MemWriteEnable} == 2'b11, 1'b0);
            if (lat_left < 0) lat_left = $urandom_range(mem_lat_max, mem_lat_min);
            if (lat_left == 0) begin
                mem_ops++;
                if (bus.o_MemWriteEnable) begin
                    base = int'(bus.o_MemAddressCache);
                    check_eq("wb_addr", bus.o_MemAddressCache, exp_wb_addr);
                    check_eq("wb_data", bus.o_MemDataToMem, exp_wb_data);
                    last_wb_addr = bus.o_MemAddressCache;
                    last_wb_data = bus.o_MemDataToMem;
                    for (int w = 0; w < 4; w++) mem[base + w] = bus.o_MemDataToMem[w*32 +: 32];
                end else begin
                    base = int'(bus.o_MemAddressCpu);
                    check_eq("refill_addr", bus.o_MemAddressCpu, exp_rd_addr);
                    last_rd_addr = bus.o_MemAddressCpu;
                    for (int w = 0; w < 4; w++) bus.i_MemDataToCache[w*32 +: 32] = mem[base + w];
                end
                bus.i_MemReady = 1'b1;
                lat_left = -1;
            end else begin
                lat_left--;
                mem_waits++;
                bus.i_MemReady = 1'b0;
            end
        end else begin
            bus.i_MemReady = 1'b0;
            lat_left = -1;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_tag[i]   = 0;
        end
        for (int a = 0; a < 1024; a++) ref_arch[a] = mem[a];
        hit_m  = 0;
        miss_m = 0;
    endtask

    task automatic prep(input logic [9:0] addr);
        int idx, tg, vbase;
        idx   = int'(addr[5:2]);
        tg    = int'(addr[9:6]);
        m_hit = res_valid[idx] && (res_tag[idx] == tg);
        m_ops = m_hit ? 0 : ((res_valid[idx] && res_dirty[idx]) ? 2 : 1);
        exp_rd_addr = {addr[9:2], 2'b00};
        vbase       = res_tag[idx] * 64 + idx * 4;
        exp_wb_addr = vbase[9:0];
        for (int w = 0; w < 4; w++) exp_wb_data[w*32 +: 32] = ref_arch[vbase + w];
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge with the request dropped.
    task automatic cpu_access(input bit wr, input logic [9:0] addr, input logic [31:0] wdata);
        int cyc, ops0, waits0, idx;
        prep(addr);
        ops0   = mem_ops;
        waits0 = mem_waits;
        bus.i_CpuAddress   = addr;
        bus.i_CpuWriteData = wdata;
        bus.i_CpuWrite     = wr;
        bus.i_CpuRead      = wr ? 1'($urandom_range(1, 0)) : 1'b1;
        cyc = 0;
        #1;
        while (bus.o_CpuStall && cyc < 60) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check_eq("stall_cycles", cyc, m_hit ? 0 : 1 + m_ops + (mem_waits - waits0));
        check_eq("rd_data", bus.o_CpuReadData, wr ? 32'h0 : ref_arch[addr]);
        check_eq("mem_ops", mem_ops - ops0, m_ops);
        idx = int'(addr[5:2]);
        if (wr) ref_arch[addr] = wdata;
        res_dirty[idx] = m_hit ? (res_dirty[idx] | wr) : wr;
        res_valid[idx] = 1'b1;
        res_tag[idx]   = int'(addr[9:6]);
        hit_m  = sat16(hit_m + 1);
        miss_m = sat16(miss_m + (m_hit ? 0 : 1));
        @(posedge clk);
        #1;
        bus.i_CpuRead  = 1'b0;
        bus.i_CpuWrite = 1'b0;
        check_eq("hit_count", bus.o_HitCount, hit_m);
        check_eq("miss_count", bus.o_MissCount, miss_m);
    endtask

    initial begin
        int n;
        bus.i_CpuAddress   = '0;
        bus.i_CpuWriteData = '0;
        bus.i_CpuRead      = 1'b0;
        bus.i_CpuWrite     = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = $urandom;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_stall", bus.o_CpuStall, 1'b0);
        check_eq("rst_rdata", bus.o_CpuReadData, 32'h0);
        check_eq("rst_re", bus.o_MemReadEnable, 1'b0);
        check_eq("rst_we", bus.o_MemWriteEnable, 1'b0);
        check_eq("rst_hits", bus.o_HitCount, 16'h0);
        check_eq("rst_misses", bus.o_MissCount, 16'h0);
        check_eq("rst_addr_cpu", bus.o_MemAddressCpu, 10'h0);
        check_eq("rst_addr_cache", bus.o_MemAddressCache, 10'h0);
        check_eq("rst_data_to_mem", bus.o_MemDataToMem, 128'h0);

        // Directed scenarios with immediate memory response.
        cpu_access(1'b0, 10'h004, 32'h0);
        check_eq("t1_refill_addr", last_rd_addr, 10'h004);
        check_eq("t1_misses", bus.o_MissCount, 16'd1);
        check_eq("t1_hits", bus.o_HitCount, 16'd1);
        cpu_access(1'b0, 10'h005, 32'h0);
        check_eq("t2_hits", bus.o_HitCount, 16'd2);
        cpu_access(1'b1, 10'h006, 32'hDEADBEEF);
        cpu_access(1'b0, 10'h046, 32'h0);
        check_eq("t3_wb_addr", last_wb_addr, 10'h004);
        check_eq("t3_wb_word2", last_wb_data[95:64], 32'hDEADBEEF);
        check_eq("t3_refill_addr", last_rd_addr, 10'h044);
        cpu_access(1'b1, 10'h3F0, 32'h12345678);
        cpu_access(1'b0, 10'h3F0, 32'h0);
        check_eq("t4_rdata", ref_arch[10'h3F0], 32'h12345678);

        // Random traffic over few indices/tags to force conflicts and write-backs.
        mem_lat_min = 0;
        mem_lat_max = 2;
        for (int i = 0; i < 250; i++) begin
            logic [9:0] a;
            a = {2'b00, 2'($urandom_range(3, 0)), 4'($urandom_range(5, 0)), 2'($urandom_range(3, 0))};
            cpu_access(1'($urandom_range(1, 0)), a, $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_stall", bus.o_CpuStall, 1'b0);
        check_eq("idle_rdata", bus.o_CpuReadData, 32'h0);
        check_eq("idle_hits", bus.o_HitCount, hit_m);
        check_eq("idle_misses", bus.o_MissCount, miss_m);

        // Reset while a refill is outstanding.
        mem_lat_min = 0;
        mem_lat_max = 0;
        cpu_access(1'b0, 10'h046, 32'h0);
        mem_lat_min = 4;
        mem_lat_max = 4;
        prep(10'h2C8);
        bus.i_CpuAddress = 10'h2C8;
        bus.i_CpuRead    = 1'b1;
        n = 0;
        while (!bus.o_MemReadEnable && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("abort_reached_alloc", bus.o_MemReadEnable, 1'b1);
        rst = 1'b1;
        bus.i_CpuRead = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_re", bus.o_MemReadEnable, 1'b0);
        check_eq("abort_we", bus.o_MemWriteEnable, 1'b0);
        check_eq("abort_stall", bus.o_CpuStall, 1'b0);
        check_eq("abort_hits", bus.o_HitCount, 16'h0);
        check_eq("abort_misses", bus.o_MissCount, 16'h0);
        @(posedge clk);
        #1;
        check_eq("abort_quiet", {bus.o_MemReadEnable, bus.o_MemWriteEnable}, 2'b00);
        model_reset();
        mem_lat_min = 0;
        mem_lat_max = 0;
        cpu_access(1'b0, 10'h046, 32'h0);
        check_eq("abort_remiss", bus.o_MissCount, 16'd1);

        // Hit counter saturation.
        bus.i_CpuAddress = 10'h046;
        bus.i_CpuRead    = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        bus.i_CpuRead = 1'b0;
        hit_m = sat16(hit_m + 65540);
        check_eq("sat_hits", bus.o_HitCount, 16'hFFFF);
        check_eq("sat_misses", bus.o_MissCount, miss_m);
        cpu_access(1'b0, 10'h047, 32'h0);
        check_eq("sat_hold", bus.o_HitCount, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
